// File: rtl/bus_turnaround_arbiter_pkg.sv
// Shared encodings, counter widths and the two-requester arbitration rule.
// Pure definitions; no clocked logic.
package bus_turnaround_arbiter_pkg;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10,
        TURN = 2'b11
    } arb_state_e;

    // On a tie the requester that did not own the bus last goes first.
    function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                            input logic last_owner);
        if (req0 && req1) return last_owner ? OWN0 : OWN1;
        else if (req0)    return OWN0;
        else if (req1)    return OWN1;
        else              return IDLE;
    endfunction

endpackage

// File: rtl/bus_turnaround_arbiter_if.sv
// Request/grant and tristate-control bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface bus_turnaround_arbiter_if;
    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic sel;
    logic oe;
    logic busy;

    modport master (output req0, output req1,
                    input grant0, input grant1, input sel, input oe, input busy);
    modport slave  (input req0, input req1,
                    output grant0, output grant1, output sel, output oe, output busy);
endinterface

// File: rtl/bus_turnaround_arbiter_arb_cycle_counter.sv
// Loadable up-counter that saturates at sat_val; tc flags count == sat_val.
// Load wins over enable; count updates one cycle after load/en, no backpressure.
module arb_cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] sat_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != sat_val)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == sat_val);

endmodule

// File: rtl/bus_turnaround_arbiter.sv
// Two-requester tristate bus arbiter with enforced oe=0 turnaround and hold-time fairness.
// Grant one cycle after request; all outputs registered; a waiting requester forces handoff after MAX_HOLD.
module bus_turnaround_arbiter
    import bus_turnaround_arbiter_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bus_turnaround_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LEN = TURN_W'(TURN_CYCLES);

    arb_state_e state_q, state_d;
    logic grant0_q, grant0_d;
    logic grant1_q, grant1_d;
    logic sel_q, sel_d;
    logic oe_q, oe_d;
    logic busy_q, busy_d;
    logic last_owner_q, last_owner_d;

    logic hold_load, hold_en, hold_tc;
    logic turn_load, turn_en, turn_tc;
    logic own_d, own_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = arb_pick(bus.req0, bus.req1, last_owner_q);
            OWN0: if (!bus.req0 || (hold_tc && bus.req1)) state_d = TURN;
            OWN1: if (!bus.req1 || (hold_tc && bus.req0)) state_d = TURN;
            TURN: if (turn_tc) state_d = arb_pick(bus.req0, bus.req1, last_owner_q);
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so the registered copies line up with state_q.
        grant0_d     = (state_d == OWN0);
        grant1_d     = (state_d == OWN1);
        oe_d         = grant0_d | grant1_d;
        busy_d       = (state_d != IDLE);
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        if (grant0_d) begin
            sel_d        = 1'b0;
            last_owner_d = 1'b0;
        end else if (grant1_d) begin
            sel_d        = 1'b1;
            last_owner_d = 1'b1;
        end

        own_d     = (state_d == OWN0) || (state_d == OWN1);
        own_q     = (state_q == OWN0) || (state_q == OWN1);
        hold_load = own_d && (state_d != state_q);
        hold_en   = own_q && (state_d == state_q);
        turn_load = (state_d == TURN) && (state_q != TURN);
        turn_en   = (state_d == TURN) && (state_q == TURN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            sel_q        <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant0_q     <= grant0_d;
            grant1_q     <= grant1_d;
            sel_q        <= sel_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            last_owner_q <= last_owner_d;
        end
    end

    arb_cycle_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (HOLD_W'(1)),
        .en       (hold_en),
        .sat_val  (HOLD_MAX),
        .tc       (hold_tc)
    );

    arb_cycle_counter #(.WIDTH(TURN_W)) u_turn_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (turn_load),
        .load_val (TURN_W'(1)),
        .en       (turn_en),
        .sat_val  (TURN_LEN),
        .tc       (turn_tc)
    );

    assign bus.grant0 = grant0_q;
    assign bus.grant1 = grant1_q;
    assign bus.sel    = sel_q;
    assign bus.oe     = oe_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bus_turnaround_arbiter.sv
// Directed bench: dut_a uses defaults (TURN=1, MAX_HOLD=8), dut_b uses TURN=3, MAX_HOLD=4.
// Output vectors are packed {grant0, grant1, sel, oe, busy}.
module tb_bus_turnaround_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_turnaround_arbiter_if ifa ();
    bus_turnaround_arbiter_if ifb ();

    bus_turnaround_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bus_turnaround_arbiter #(.TURN_CYCLES(3), .MAX_HOLD(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    localparam logic [4:0] V_OWN0  = 5'b10011;
    localparam logic [4:0] V_OWN1  = 5'b01111;
    localparam logic [4:0] V_TURN0 = 5'b00001;
    localparam logic [4:0] V_TURN1 = 5'b00101;
    localparam logic [4:0] V_IDLE0 = 5'b00000;
    localparam logic [4:0] V_IDLE1 = 5'b00100;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs(input int d);
        if (d == 0) return {ifa.grant0, ifa.grant1, ifa.sel, ifa.oe, ifa.busy};
        else        return {ifb.grant0, ifb.grant1, ifb.sel, ifb.oe, ifb.busy};
    endfunction

    task automatic set_req(input int d, input logic r0, input logic r1);
        if (d == 0) begin
            ifa.req0 = r0;
            ifa.req1 = r1;
        end else begin
            ifb.req0 = r0;
            ifb.req1 = r1;
        end
    endtask

    // Apply requests, let one rising edge sample them, then check outputs 1ns later.
    task automatic step(input int d, input logic r0, input logic r1,
                        input logic [4:0] exp, input string tag);
        set_req(d, r0, r1);
        @(posedge clk);
        #1;
        check(tag, 32'(outs(d)), 32'(exp));
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_outs_a", 32'(outs(0)), 32'(V_IDLE0));
        check("rst_outs_b", 32'(outs(1)), 32'(V_IDLE0));
        check("rst_state_a", 32'(dut_a.state_q), 32'd0);
        check("rst_last_owner_a", 32'(dut_a.last_owner_q), 32'd1);
        check("rst_hold_cnt_a", 32'(dut_a.u_hold_cnt.count_q), 32'd0);
        check("rst_turn_cnt_b", 32'(dut_b.u_turn_cnt.count_q), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Mutual exclusion of grants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mutex_a", 32'(ifa.grant0 & ifa.grant1), 32'd0);
            check("mutex_b", 32'(ifb.grant0 & ifb.grant1), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        set_req(0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0);
        do_reset();

        // Single requester: 3-cycle ownership, one TURN cycle, back to IDLE.
        step(0, 1'b1, 1'b0, V_OWN0,  "s1_own0_c1");
        step(0, 1'b1, 1'b0, V_OWN0,  "s1_own0_c2");
        step(0, 1'b1, 1'b0, V_OWN0,  "s1_own0_c3");
        step(0, 1'b0, 1'b0, V_TURN0, "s1_turn");
        step(0, 1'b0, 1'b0, V_IDLE0, "s1_idle");
        step(0, 1'b0, 1'b0, V_IDLE0, "s1_idle_stay");

        // Simultaneous requests after reset: requester 0 wins the tie.
        do_reset();
        step(0, 1'b1, 1'b1, V_OWN0,  "s2_own0_c1");
        step(0, 1'b1, 1'b1, V_OWN0,  "s2_own0_c2");
        step(0, 1'b0, 1'b1, V_TURN0, "s2_turn");
        step(0, 1'b0, 1'b1, V_OWN1,  "s2_own1");
        step(0, 1'b0, 1'b0, V_TURN1, "s2_turn_sel_held");
        step(0, 1'b0, 1'b0, V_IDLE1, "s2_idle_sel_held");

        // Forced handoff at MAX_HOLD=4 with a 3-cycle turnaround.
        step(1, 1'b1, 1'b0, V_OWN0,  "s3_own0_c1");
        step(1, 1'b1, 1'b1, V_OWN0,  "s3_own0_c2");
        step(1, 1'b1, 1'b1, V_OWN0,  "s3_own0_c3");
        step(1, 1'b1, 1'b1, V_OWN0,  "s3_own0_c4");
        for (int i = 1; i <= 3; i++) step(1, 1'b1, 1'b1, V_TURN0, $sformatf("s3_turn0_c%0d", i));
        for (int i = 1; i <= 4; i++) step(1, 1'b1, 1'b1, V_OWN1, $sformatf("s3_own1_c%0d", i));
        step(1, 1'b1, 1'b1, V_TURN1, "s3_turn1_c1");
        step(1, 1'b1, 1'b0, V_TURN1, "s3_turn1_c2");
        step(1, 1'b1, 1'b0, V_TURN1, "s3_turn1_c3");
        step(1, 1'b1, 1'b0, V_OWN0,  "s3_regain0");
        for (int i = 1; i <= 3; i++) step(1, 1'b0, 1'b0, V_TURN0, $sformatf("s3_rel_turn_c%0d", i));
        step(1, 1'b0, 1'b0, V_IDLE0, "s3_idle");

        // Owner drops while the other rises in the same cycle, then async reset mid-OWN1.
        step(0, 1'b1, 1'b0, V_OWN0,  "s4_own0");
        step(0, 1'b0, 1'b1, V_TURN0, "s4_swap_turn");
        step(0, 1'b0, 1'b1, V_OWN1,  "s4_own1");
        #3;
        rst_n = 1'b0;
        #1;
        check("s4_async_rst_outs", 32'(outs(0)), 32'(V_IDLE0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s4_first_arb_after_rst", 32'(outs(0)), 32'(V_OWN1));
        step(0, 1'b0, 1'b0, V_TURN1, "s4_turn");
        step(0, 1'b0, 1'b0, V_IDLE1, "s4_idle");

        // Lone requester holds 300 cycles: no forced release, hold count saturates at 8.
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            step(0, 1'b0, 1'b1, V_OWN1, $sformatf("s5_own1_c%0d", i));
            check($sformatf("s5_hold_cnt_c%0d", i), 32'(dut_a.u_hold_cnt.count_q),
                  (i < 8) ? 32'(i) : 32'd8);
        end
        step(0, 1'b0, 1'b0, V_TURN1, "s5_turn");
        step(0, 1'b0, 1'b0, V_IDLE1, "s5_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_turnaround_arbiter.md
BUS_TURNAROUND_ARBITER -- requirements
Module: bus_turnaround_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, default 1, sets the bus-released cycles on every ownership release; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 8, sets the owner cycles after which a waiting requester forces handoff; legal range 1..255.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 Port req0, input, 1, requester 0 wants the shared 2:1 tristate bus; held high while needed.
REQ-006 Port req1, input, 1, requester 1 wants the bus; same rules as req0.
REQ-007 Port grant0, output, 1, requester 0 owns the bus this cycle.
REQ-008 Port grant1, output, 1, requester 1 owns the bus this cycle.
REQ-009 Port sel, output, 1, mux select to the tristate buffer pair (0 = in0 path, 1 = in1 path).
REQ-010 Port oe, output, 1, bus drive enable; 0 means both buffers high-Z.
REQ-011 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, OWN0, OWN1 and TURN; all outputs SHALL be registered.
REQ-013 In IDLE: only req0 -> OWN0; only req1 -> OWN1; both -> OWN of the requester that is not last_owner; neither -> stay.
REQ-014 Grant latency from IDLE SHALL be 1 cycle: req sampled at edge N, grant high after edge N.
REQ-015 In OWNx: grantx=1, other grant=0, sel=x, oe=1; last_owner SHALL be set to x on entry.
REQ-016 Hold counter SHALL load 1 on entry to OWNx, increment each OWNx cycle and saturate at MAX_HOLD.
REQ-017 OWNx SHALL go to TURN when reqx=0, or when hold counter = MAX_HOLD and the other req=1.
REQ-018 Otherwise OWNx SHALL stay, including at saturation with the other req low.
REQ-019 In TURN: grant0=grant1=0, oe=0, sel holds the previous owner value, busy=1.
REQ-020 TURN SHALL last exactly TURN_CYCLES cycles, counted by a turn counter loaded on entry.
REQ-021 At the end of TURN, arbitration SHALL follow the IDLE rules (REQ-013); if no req is pending, next state is IDLE.
REQ-022 grant0 and grant1 SHALL never be high together, and oe=1 iff exactly one grant is high.
REQ-023 sel SHALL change only on entry to OWNx, never in TURN or IDLE, to avoid glitches.
REQ-024 Every change of owner SHALL pass through at least TURN_CYCLES cycles with oe=0.
REQ-025 Simultaneous reqx drop and other-req rise in OWNx SHALL go to TURN, then grant the other requester.

Reset
REQ-026 With rst_n low: state=IDLE, grant0=0, grant1=0, oe=0, busy=0, sel=0, last_owner=1, both counters 0.
REQ-027 Reset mid-ownership or mid-TURN SHALL drop grants and oe immediately, without waiting for a clock.
REQ-028 First arbitration after reset release SHALL see req inputs at the first rising edge with rst_n high.

Structure
REQ-029 A shared definitions file SHALL hold the state encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10, TURN=2'b11) and the counter widths (hold 8 bits, turn 4 bits).
REQ-030 One sub-module, arb_cycle_counter (load, enable, saturate, terminal-count flag), SHALL be instantiated twice: hold counter and turn counter.

Verification
REQ-031 Reset, then req0=1 for 3 cycles then 0 -> grant0 high 3 cycles one cycle after req0, sel=0, oe=1, then 1 TURN cycle with oe=0, then IDLE.
REQ-032 From reset, req0=req1=1 in the same cycle -> grant0 first (last_owner=1); after req0 drops: 1 TURN cycle, then grant1, sel=1.
REQ-033 MAX_HOLD=4, req0 held high and req1 raised at cycle 2 of OWN0 -> grant0 exactly 4 cycles, TURN, grant1; req0 still high -> regains bus after req1 hold/release.
REQ-034 TURN_CYCLES=3, owner switch -> exactly 3 cycles with oe=0 and both grants 0, sel constant; the continuous assertion grant0&grant1 never fires.
REQ-035 rst_n pulsed low mid-OWN1 between clock edges -> grant1, oe and busy fall at the rst_n edge; sel=0 after reset.
REQ-036 req1 alone held 300 cycles with MAX_HOLD=8 -> grant1 stays high throughout and the hold counter saturates at 8 without wrapping.
